// File: rtl/adc_capture_pkg.sv
// Shared types and helpers for the ADC frame capture front-end.
package adc_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_CS_HOLD
  } cap_state_e;

  localparam int unsigned STATUS_WORD_IDX = 0;
  localparam int          OUT_W           = 32;

  // Sign-extend the low 'bits' bits of w to OUT_W bits.
  function automatic logic [OUT_W-1:0] sign_ext(input logic [OUT_W-1:0] w, input int bits);
    logic [OUT_W-1:0] sh;
    sh = w << (OUT_W - bits);
    return $unsigned($signed(sh) >>> (OUT_W - bits));
  endfunction

endpackage

// File: rtl/adc_frame_capture_if.sv
// Valid/ready word stream from the capture block to the register block FIFO.
interface adc_frame_capture_if;
  import adc_capture_pkg::*;

  logic             m_valid;
  logic [OUT_W-1:0] m_data;
  logic             m_last;
  logic             m_ready;

  modport master (output m_valid, m_data, m_last, input  m_ready);
  modport slave  (input  m_valid, m_data, m_last, output m_ready);
endinterface

// File: rtl/adc_frame_capture_sync_fall_detect.sv
// Two-flop synchronizer with a falling-edge pulse; flops reset high so an
// idle-high input never produces a spurious edge after reset.
module sync_fall_detect (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic fall
);
  // [0],[1] synchronize; [2] is the previous synchronized value
  logic [2:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[1:0], async_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '1;
    else     sync_q <= sync_d;
  end

  assign fall = sync_q[2] & ~sync_q[1];
endmodule

// File: rtl/adc_frame_capture.sv
// SPI frame capture for the load-cell ADC: on DRDY or snapshot, shifts one
// status word plus N channel words out of the ADC and streams them as 32-bit words.
module adc_frame_capture
  import adc_capture_pkg::*;
#(
  parameter int NUM_CH    = 8,
  parameter int WORD_BITS = 24,
  parameter int SCLK_DIV  = 4
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                enable,
  input  logic [3:0]          num_ch,
  input  logic                snapshot_req,
  input  logic                adc_drdy_n,
  input  logic                adc_miso,
  output logic                adc_cs_n,
  output logic                adc_sclk,
  output logic                adc_mosi,
  adc_frame_capture_if.master m,
  output logic                busy,
  output logic                frame_done,
  output logic                trig_missed,
  output logic                word_dropped,
  output logic [31:0]         frame_count
);

  localparam int DIV_W = $clog2(SCLK_DIV);
  localparam int BIT_W = $clog2(WORD_BITS);
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(SCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_BITS - 1);

  logic drdy_fall, trig;

  sync_fall_detect u_drdy_sync (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .async_in (adc_drdy_n),
    .fall     (drdy_fall)
  );

  assign trig = snapshot_req | (enable & drdy_fall);

  cap_state_e           state_q, state_d;
  logic [DIV_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [3:0]           word_q, word_d;
  logic [3:0]           nch_q, nch_d;
  logic [WORD_BITS-2:0] shift_q, shift_d;
  logic                 cs_n_q, cs_n_d;
  logic                 sclk_q, sclk_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 missed_q, missed_d;
  logic                 drop_q, drop_d;
  logic [31:0]          fcnt_q, fcnt_d;
  logic                 mvalid_q, mvalid_d;
  logic [OUT_W-1:0]     mdata_q, mdata_d;
  logic                 mlast_q, mlast_d;

  logic             ph_end, word_done;
  logic [3:0]       nch_sel;
  logic [OUT_W-1:0] raw_word;

  assign nch_sel  = (num_ch == 4'd0 || num_ch > 4'(NUM_CH)) ? 4'(NUM_CH) : num_ch;
  // The final bit is taken straight from the pin so the word can load the
  // output register on the same edge that samples it.
  assign raw_word = OUT_W'({shift_q, adc_miso});
  assign ph_end   = (cnt_q == DIV_MAX);

  always_comb begin
    state_d   = state_q;
    cnt_d     = ph_end ? '0 : cnt_q + DIV_W'(1);
    bit_d     = bit_q;
    word_d    = word_q;
    nch_d     = nch_q;
    shift_d   = shift_q;
    cs_n_d    = cs_n_q;
    sclk_d    = sclk_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    missed_d  = 1'b0;
    drop_d    = 1'b0;
    fcnt_d    = fcnt_q;
    mvalid_d  = mvalid_q;
    mdata_d   = mdata_q;
    mlast_d   = mlast_q;
    word_done = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (trig) begin
          state_d = ST_CS_SETUP;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          nch_d   = nch_sel;
          bit_d   = '0;
          word_d  = '0;
        end
      end
      ST_CS_SETUP: begin
        if (ph_end) begin
          state_d = ST_SHIFT;
          sclk_d  = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (ph_end) begin
          if (sclk_q) begin
            // falling SCLK: sample MISO, MSB first
            sclk_d    = 1'b0;
            shift_d   = raw_word[WORD_BITS-2:0];
            word_done = (bit_q == BIT_LAST);
          end else if (bit_q == BIT_LAST && word_q == nch_q) begin
            state_d = ST_CS_HOLD;
          end else begin
            sclk_d = 1'b1;
            if (bit_q == BIT_LAST) begin
              bit_d  = '0;
              word_d = word_q + 4'd1;
            end else begin
              bit_d = bit_q + BIT_W'(1);
            end
          end
        end
      end
      ST_CS_HOLD: begin
        if (ph_end) begin
          state_d = ST_IDLE;
          cs_n_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          fcnt_d  = fcnt_q + 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (trig && state_q != ST_IDLE) missed_d = 1'b1;

    // Single output register; ADC timing is fixed, so a word that finds the
    // register still occupied is dropped instead of stalling SCLK.
    if (word_done) begin
      if (mvalid_q && !m.m_ready) begin
        drop_d = 1'b1;
      end else begin
        mvalid_d = 1'b1;
        mdata_d  = (word_q == 4'(STATUS_WORD_IDX)) ? raw_word : sign_ext(raw_word, WORD_BITS);
        mlast_d  = (word_q == nch_q);
      end
    end else if (mvalid_q && m.m_ready) begin
      mvalid_d = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      word_q   <= '0;
      nch_q    <= '0;
      shift_q  <= '0;
      cs_n_q   <= 1'b1;
      sclk_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      missed_q <= 1'b0;
      drop_q   <= 1'b0;
      fcnt_q   <= '0;
      mvalid_q <= 1'b0;
      mdata_q  <= '0;
      mlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      word_q   <= word_d;
      nch_q    <= nch_d;
      shift_q  <= shift_d;
      cs_n_q   <= cs_n_d;
      sclk_q   <= sclk_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      missed_q <= missed_d;
      drop_q   <= drop_d;
      fcnt_q   <= fcnt_d;
      mvalid_q <= mvalid_d;
      mdata_q  <= mdata_d;
      mlast_q  <= mlast_d;
    end
  end

  assign adc_cs_n     = cs_n_q;
  assign adc_sclk     = sclk_q;
  assign adc_mosi     = 1'b0;
  assign busy         = busy_q;
  assign frame_done   = done_q;
  assign trig_missed  = missed_q;
  assign word_dropped = drop_q;
  assign frame_count  = fcnt_q;
  assign m.m_valid    = mvalid_q;
  assign m.m_data     = mdata_q;
  assign m.m_last     = mlast_q;

endmodule
